// File: rtl/salu_issue_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : salu_issue_arbiter_pkg
// Brief   : Shared types and constants for the SALU issue arbiter slice.
// Revision: 1.0
// ============================================================================
package salu_issue_arbiter_pkg;

    localparam int WFID_W         = 6;
    localparam int NUM_WF_DEFAULT = 40;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/salu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : salu_issue_arbiter_if
// Brief   : Wavepool/SALU-side signal bundle of the SALU issue arbiter.
// Revision: 1.0
// ============================================================================
interface salu_issue_arbiter_if
    import salu_issue_arbiter_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEFAULT
) ();

    logic [NUM_WF-1:0]  wf_req;
    logic               issue_alu_ready;
    logic               sgpr_instr_done;
    logic [WFID_W-1:0]  sgpr_instr_done_wfid;
    logic               halt_req;

    logic               issue_alu_select;
    logic [WFID_W-1:0]  issue_wfid;
    logic [NUM_WF-1:0]  wf_busy;
    logic [3:0]         inflight_cnt;
    logic               halt_ack;
    logic               err_spurious_done;

    modport master (
        output wf_req, issue_alu_ready, sgpr_instr_done, sgpr_instr_done_wfid, halt_req,
        input  issue_alu_select, issue_wfid, wf_busy, inflight_cnt, halt_ack, err_spurious_done
    );

    modport slave (
        input  wf_req, issue_alu_ready, sgpr_instr_done, sgpr_instr_done_wfid, halt_req,
        output issue_alu_select, issue_wfid, wf_busy, inflight_cnt, halt_ack, err_spurious_done
    );

endinterface
`default_nettype wire

// File: rtl/salu_issue_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : salu_rr_picker
// Brief   : Combinational wrapped first-set search starting at a pointer.
// Revision: 1.0
// ============================================================================
module salu_rr_picker
    import salu_issue_arbiter_pkg::*;
#(
    parameter int N = NUM_WF_DEFAULT
) (
    input  logic [N-1:0]       i_req,
    input  logic [WFID_W-1:0]  i_start,
    output logic               o_found,
    output logic [WFID_W-1:0]  o_idx
);

    logic [WFID_W:0] w_pos;

    // Walk downward so the last hit written is the nearest one above i_start.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = {1'b0, i_start} + (WFID_W + 1)'(i);
            if (w_pos >= (WFID_W + 1)'(N)) begin
                w_pos = w_pos - (WFID_W + 1)'(N);
            end
            if (i_req[w_pos[WFID_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_pos[WFID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/salu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : salu_issue_arbiter
// Brief   : Round-robin SALU issue scheduler with in-flight cap and drain/halt.
// Revision: 1.0
// ============================================================================
module salu_issue_arbiter
    import salu_issue_arbiter_pkg::*;
#(
    parameter int NUM_WF       = NUM_WF_DEFAULT,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    salu_issue_arbiter_if.slave  bus
);

    localparam logic [NUM_WF-1:0] c_ONE = {{(NUM_WF-1){1'b0}}, 1'b1};

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [WFID_W-1:0]   r_rr_ptr;
    logic [NUM_WF-1:0]   r_busy;
    logic [3:0]          r_cnt;
    logic                r_sel;
    logic [WFID_W-1:0]   r_wfid;
    logic                r_err;

    logic [NUM_WF-1:0]   w_elig;
    logic                w_found;
    logic [WFID_W-1:0]   w_idx;
    logic                w_grant;
    logic [NUM_WF-1:0]   w_gnt_mask;
    logic [NUM_WF-1:0]   w_done_mask;
    logic                w_done_hit;

    assign w_elig = bus.wf_req & ~r_busy;

    salu_rr_picker #(.N(NUM_WF)) u_picker (
        .i_req   (w_elig),
        .i_start (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // halt_req is honoured in the same cycle it is first seen in RUN.
    assign w_grant = (r_state == ST_RUN) && !bus.halt_req && bus.issue_alu_ready
                   && (r_cnt < 4'(MAX_INFLIGHT)) && w_found;

    // An out-of-range done wfid shifts the one-hot off the end, so it never hits.
    assign w_gnt_mask  = c_ONE << w_idx;
    assign w_done_mask = c_ONE << bus.sgpr_instr_done_wfid;
    assign w_done_hit  = bus.sgpr_instr_done && |(w_done_mask & r_busy);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (bus.halt_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.halt_req)        w_state_nxt = ST_RUN;
                else if (r_cnt == 4'd0)   w_state_nxt = ST_HALTED;
            end
            ST_HALTED: if (!bus.halt_req) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_rr_ptr <= '0;
            r_busy   <= '0;
            r_cnt    <= 4'd0;
            r_sel    <= 1'b0;
            r_wfid   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_grant;
            r_busy  <= (r_busy | (w_grant ? w_gnt_mask : '0))
                     & ~(w_done_hit ? w_done_mask : '0);
            if (w_grant && !w_done_hit) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (!w_grant && w_done_hit) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_grant) begin
                r_wfid   <= w_idx;
                r_rr_ptr <= (w_idx == WFID_W'(NUM_WF - 1)) ? '0 : w_idx + 1'b1;
            end
            if (bus.sgpr_instr_done && !w_done_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.issue_alu_select  = r_sel;
    assign bus.issue_wfid        = r_wfid;
    assign bus.wf_busy           = r_busy;
    assign bus.inflight_cnt      = r_cnt;
    assign bus.halt_ack          = (r_state == ST_HALTED);
    assign bus.err_spurious_done = r_err;

endmodule
`default_nettype wire

// File: doc/salu_issue_arbiter.md
# salu_issue_arbiter

Round-robin scheduler that shares the single scalar ALU among up to NUM_WF wavefronts. Each cycle it picks one eligible wavefront that has a SALU instruction pending and drives the SALU's issue_alu_select/issue_wfid. It tracks which wavefronts have instructions in flight until the SALU reports sgpr_instr_done, and caps total outstanding issues. A drain/halt handshake lets the wavepool quiesce the SALU.

## Interface
- NUM_WF, 40: number of wavefront slots; wfid width fixed at 6.
- MAX_INFLIGHT, 4: maximum outstanding SALU issues, 1..15.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wf_req  input  NUM_WF  bit w = wavefront w has a SALU instruction ready.
- issue_alu_ready  input  1  SALU can accept an issue this cycle.
- sgpr_instr_done  input  1  SALU retired one instruction.
- sgpr_instr_done_wfid  input  6  wavefront of the retired instruction.
- halt_req  input  1  level; request drain and halt.
- issue_alu_select  output  1  one-cycle issue pulse to SALU.
- issue_wfid  output  6  wavefront being issued; valid with issue_alu_select.
- wf_busy  output  NUM_WF  bit w = wavefront w has an instruction in flight.
- inflight_cnt  output  4  number of outstanding issues.
- halt_ack  output  1  high while in HALTED.
- err_spurious_done  output  1  sticky; done received for a non-busy or out-of-range wfid.

## Operation
- Eligible set E = wf_req & ~wf_busy.
- Grant condition G = state==RUN & issue_alu_ready & inflight_cnt<MAX_INFLIGHT & E!=0.
- On G: winner w = first set bit of E searching upward from rr_ptr, wrapping at NUM_WF-1 -> 0.
  - Register issue_alu_select=1 and issue_wfid=w.
  - Set wf_busy[w] and increment inflight_cnt.
  - rr_ptr <= (w==NUM_WF-1) ? 0 : w+1.
- Without G, issue_alu_select registers 0 and issue_wfid holds its last value.
- On sgpr_instr_done with wfid d < NUM_WF and wf_busy[d]=1: clear wf_busy[d] and decrement inflight_cnt.
- Otherwise (d >= NUM_WF or wf_busy[d]=0): no state change; set err_spurious_done, cleared only by reset.
- Same-cycle grant and valid done: both apply, so inflight_cnt is unchanged; wf_busy sets w and clears d (w != d, since w was not busy).
- A done that frees a slot at the cap does not enable a grant in the same cycle. The cap check uses the registered count.
- State machine:
  - RUN: grants allowed. halt_req=1 -> DRAIN.
  - DRAIN: no grants. inflight_cnt==0 -> HALTED. halt_req=0 -> RUN.
  - HALTED: halt_ack=1, no grants. halt_req=0 -> RUN.
  - RUN with halt_req=1 and inflight_cnt==0 still passes through DRAIN (one cycle) before HALTED.
- Reset mid-operation: all in-flight tracking is discarded. Any later done is flagged spurious.

## Timing
- Reset values: issue_alu_select=0, issue_wfid=0, wf_busy=0, inflight_cnt=0, halt_ack=0, err_spurious_done=0, rr_ptr=0, state=RUN.
- Grant latency: the inputs sampled at edge k produce issue_alu_select high for exactly the cycle after edge k.
- Maximum issue rate is 1 per cycle, to different wavefronts. A wavefront cannot reissue until its done has been seen; it is eligible again the cycle after the done edge.
- halt_req at edge k stops grants from edge k (no issue pulse in the following cycle). halt_ack rises at the edge after DRAIN sees inflight_cnt==0.
- Done inputs are sampled every cycle in every state.

## Structure
- Shared package holds:
  - the state encoding (RUN=0, DRAIN=1, HALTED=2);
  - WFID_W=6;
  - the NUM_WF default.
- One sub-module: salu_rr_picker. It is combinational; given a request vector and a start pointer, it returns a found flag and the wrapped first-set index. It is reusable by the VALU/LSU arbiters.
- All state lives in the top module: rr_ptr, wf_busy, counter, FSM, output registers.

## Test plan
- Single request: wf_req bit 2, issue_alu_ready=1 after reset -> next cycle issue_alu_select=1, issue_wfid=2, wf_busy[2]=1, inflight_cnt=1. No reissue of wf 2 until sgpr_instr_done with wfid 2.
- Fairness: wf_req bits 0, 5, 39 held, done returned 1 cycle after each issue -> issue order 0, 5, 39, 0, 5 (pointer wraps 39 -> 0).
- Cap: MAX_INFLIGHT=4, wf_req bits 0..7, no dones -> exactly 4 issues (wf 0, 1, 2, 3), inflight_cnt=4, then no pulses. One done for wf 1 -> wf 4 issues in the cycle after the following edge.
- Simultaneous: grant of wf 6 in the same cycle as done for wf 3 -> inflight_cnt unchanged, wf_busy[6]=1, wf_busy[3]=0.
- Halt: 2 in flight, halt_req=1 -> no pulses; after both dones, halt_ack=1. halt_req=0 -> halt_ack=0 and grants resume next cycle.
- Error and reset: done with wfid 45, or for an idle wf -> err_spurious_done=1 and counters unchanged. Assert rst low mid-run -> all outputs return to their reset values immediately.
